lsu_lq: RTL and testbench
=========================

// Module: lsu_lq
// PURPOSE
//  Load queue: tracks issued loads from allocation until ROB retirement and
//  snoops the store-retire broadcast from the store queue. Any queued load whose
//  bytes overlap a retiring store executed speculatively with stale data. Such a
//  load is flagged, and the ROB is told at load retire so it can flush and replay.
//  Sits in the LSU beside the store queue; driven by LSU_ID (alloc), SQ (snoop), ROB (retire).
// PARAMETERS
//  ADDR_WIDTH    32  load/store address width
//  TAG_WIDTH     6   ROB tag width
//  LQ_DEPTH      8   number of LQ slots
//  LQ_TAG_WIDTH  3   log2(LQ_DEPTH), slot index width
// PORTS
//  clk                         in   1           clock
//  n_rst                       in   1           reset, asynchronous, active-low
//  i_flush                     in   1           pipeline flush, invalidates all slots
//  o_full                      out  1           no empty slot
//  i_alloc_tag                 in   TAG_WIDTH   ROB tag of new load
//  i_alloc_addr                in   ADDR_WIDTH  load address
//  i_alloc_width               in   4           load byte-enable mask within word
//  i_alloc_en                  in   1           allocate request
//  i_sq_retire_addr            in   ADDR_WIDTH  retiring store address
//  i_sq_retire_width           in   4           retiring store byte-enable mask
//  i_sq_retire_en              in   1           store retiring this cycle
//  i_lq_retire_tag             in   TAG_WIDTH   ROB tag of load being retired
//  i_lq_retire_en              in   1           ROB retires a load this cycle
//  o_lq_retire_valid           out  1           a valid slot matched i_lq_retire_tag
//  o_lq_retire_mis_speculated  out  1           matched load must be replayed
// BEHAVIOUR
//  - Slot state: addr, width, tag, valid, mis_spec. Reset/flush: all valid=0, mis_spec=0.
//  - Flush wins over alloc, snoop and retire in the same cycle.
//  - o_full = no slot with valid=0; combinational from current state; 0 after reset.
//  - Alloc: when i_alloc_en && !o_full, the lowest-index empty slot is written at the
//    next edge: valid=1, fields latched. mis_spec = same-cycle snoop overlap (see below),
//    else 0. i_alloc_en while full is dropped silently; no state change.
//  - Overlap(load, store): addr[ADDR_WIDTH-1:2] equal AND |(load.width & store.width).
//  - Snoop: when i_sq_retire_en, every valid slot that overlaps gets mis_spec<=1 (sticky).
//    Stores retire in order, so every queued load is younger than the retiring store.
//  - Retire match: the single valid slot with tag==i_lq_retire_tag (at most one by construction).
//    Outputs are combinational with zero latency:
//      o_lq_retire_valid = i_lq_retire_en && match
//      o_lq_retire_mis_speculated = o_lq_retire_valid && (slot.mis_spec || same-cycle snoop overlap)
//    The matched slot gets valid<=0, mis_spec<=0 at the next edge.
//    With no match: both outputs are 0 and there is no state change.
//  - Simultaneous alloc+retire: alloc selects from the pre-edge empty vector, so
//    retire-freed slots are reusable only from the next cycle. When full, alloc is still rejected.
//  - Simultaneous alloc+snoop+retire are independent and all take effect in the same edge.
//  - Outputs after reset: o_full=0, o_lq_retire_valid=0, o_lq_retire_mis_speculated=0.
//  - Implementation: one-hot alloc select via empty & ~(empty-1); one-hot to binary for
//    the retire index. Data fields are not reset; only valid/mis_spec are reset.
// TESTING
//  1. Alloc tags 1..8 (LQ_DEPTH=8) -> o_full=1 after 8th; 9th alloc (tag 9) dropped;
//     retire tag 9 -> valid=0.
//  2. Alloc load tag 3 addr 0x100 width 0x3; store retire addr 0x100 width 0xC
//     -> no flag. Store retire addr 0x100 width 0x2 -> retire tag 3 gives valid=1, mis_spec=1.
//  3. Alloc load addr 0x104 width 0xF; store retire addr 0x100 width 0xF
//     -> retire gives mis_spec=0.
//  4. Store retire 0x200/0x1 in same cycle as retire of load 0x200/0x1 with mis_spec=0
//     -> mis_spec=1 that cycle. The same snoop in the same cycle as alloc of load
//     0x200/0x1 -> later retire gives mis_spec=1.
//  5. Fill 4 slots with one flagged; assert i_flush together with alloc and retire
//     -> all empty, o_full=0; retiring the old tags gives valid=0.
//  6. Full queue: retire tag 5 and alloc tag 20 in the same cycle -> alloc dropped;
//     next cycle alloc tag 20 lands in the freed slot.
//     Assert n_rst mid-stream -> outputs 0 immediately.

Source files
------------

// File: rtl/lsu_lq_if.sv
// Load-queue port bundle: LSU_ID allocation, SQ store-retire snoop, ROB load retire.
// The master modport drives requests; the slave modport is the load queue itself.
interface lsu_lq_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int TAG_WIDTH  = 6
);
  logic                  i_flush;
  logic                  o_full;
  logic [TAG_WIDTH-1:0]  i_alloc_tag;
  logic [ADDR_WIDTH-1:0] i_alloc_addr;
  logic [3:0]            i_alloc_width;
  logic                  i_alloc_en;
  logic [ADDR_WIDTH-1:0] i_sq_retire_addr;
  logic [3:0]            i_sq_retire_width;
  logic                  i_sq_retire_en;
  logic [TAG_WIDTH-1:0]  i_lq_retire_tag;
  logic                  i_lq_retire_en;
  logic                  o_lq_retire_valid;
  logic                  o_lq_retire_mis_speculated;

  modport master (
    output i_flush, i_alloc_tag, i_alloc_addr, i_alloc_width, i_alloc_en,
           i_sq_retire_addr, i_sq_retire_width, i_sq_retire_en,
           i_lq_retire_tag, i_lq_retire_en,
    input  o_full, o_lq_retire_valid, o_lq_retire_mis_speculated
  );

  modport slave (
    input  i_flush, i_alloc_tag, i_alloc_addr, i_alloc_width, i_alloc_en,
           i_sq_retire_addr, i_sq_retire_width, i_sq_retire_en,
           i_lq_retire_tag, i_lq_retire_en,
    output o_full, o_lq_retire_valid, o_lq_retire_mis_speculated
  );
endinterface

// File: rtl/lsu_lq.sv
// Load queue: holds issued loads until ROB retirement and flags any load whose
// bytes overlap a retiring store, so the ROB can flush and replay it.
module lsu_lq #(
  parameter int ADDR_WIDTH   = 32,
  parameter int TAG_WIDTH    = 6,
  parameter int LQ_DEPTH     = 8,
  parameter int LQ_TAG_WIDTH = 3
) (
  input logic     clk,
  input logic     n_rst,
  lsu_lq_if.slave bus
);

  logic [LQ_DEPTH-1:0]   valid_q, valid_d;
  logic [LQ_DEPTH-1:0]   mis_q, mis_d;
  logic [ADDR_WIDTH-1:0] addr_q  [LQ_DEPTH];
  logic [ADDR_WIDTH-1:0] addr_d  [LQ_DEPTH];
  logic [3:0]            width_q [LQ_DEPTH];
  logic [3:0]            width_d [LQ_DEPTH];
  logic [TAG_WIDTH-1:0]  tag_q   [LQ_DEPTH];
  logic [TAG_WIDTH-1:0]  tag_d   [LQ_DEPTH];

  logic [LQ_DEPTH-1:0]     empty;
  logic [LQ_DEPTH-1:0]     alloc_oh;
  logic                    alloc_fire;
  logic                    alloc_snoop;
  logic [LQ_DEPTH-1:0]     snoop_hit;
  logic [LQ_DEPTH-1:0]     match;
  logic [LQ_TAG_WIDTH-1:0] ret_idx;
  logic                    ret_valid;

  function automatic logic overlap(input logic [ADDR_WIDTH-1:0] la, input logic [3:0] lw,
                                   input logic [ADDR_WIDTH-1:0] sa, input logic [3:0] sw);
    return (la[ADDR_WIDTH-1:2] == sa[ADDR_WIDTH-1:2]) && |(lw & sw);
  endfunction

  assign empty       = ~valid_q;
  assign alloc_oh    = empty & ~(empty - LQ_DEPTH'(1));
  assign alloc_fire  = bus.i_alloc_en && !bus.o_full && !bus.i_flush;
  assign alloc_snoop = bus.i_sq_retire_en &&
                       overlap(bus.i_alloc_addr, bus.i_alloc_width,
                               bus.i_sq_retire_addr, bus.i_sq_retire_width);

  always_comb begin
    snoop_hit = '0;
    match     = '0;
    ret_idx   = '0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      snoop_hit[i] = bus.i_sq_retire_en && valid_q[i] &&
                     overlap(addr_q[i], width_q[i], bus.i_sq_retire_addr, bus.i_sq_retire_width);
      match[i]     = valid_q[i] && (tag_q[i] == bus.i_lq_retire_tag);
      // Tags are unique among valid slots, so OR-ing indices is a one-hot encoder.
      if (match[i]) ret_idx = ret_idx | LQ_TAG_WIDTH'(i);
    end
  end

  assign ret_valid                      = bus.i_lq_retire_en && |match;
  assign bus.o_full                     = &valid_q;
  assign bus.o_lq_retire_valid          = ret_valid;
  assign bus.o_lq_retire_mis_speculated = ret_valid && (mis_q[ret_idx] || snoop_hit[ret_idx]);

  always_comb begin
    valid_d = valid_q;
    mis_d   = mis_q | snoop_hit;
    addr_d  = addr_q;
    width_d = width_q;
    tag_d   = tag_q;
    // The alloc target is an empty slot, so it never collides with the retiring one.
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (alloc_fire && alloc_oh[i]) begin
        valid_d[i] = 1'b1;
        mis_d[i]   = alloc_snoop;
        addr_d[i]  = bus.i_alloc_addr;
        width_d[i] = bus.i_alloc_width;
        tag_d[i]   = bus.i_alloc_tag;
      end
    end
    if (ret_valid) begin
      valid_d = valid_d & ~match;
      mis_d   = mis_d & ~match;
    end
    if (bus.i_flush) begin
      valid_d = '0;
      mis_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      valid_q <= '0;
      mis_q   <= '0;
    end else begin
      valid_q <= valid_d;
      mis_q   <= mis_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    width_q <= width_d;
    tag_q   <= tag_d;
  end

endmodule

// File: tb/tb_lsu_lq.sv
// Directed bench for lsu_lq: fill/full, byte overlap, same-cycle snoop, flush, async reset.
module tb_lsu_lq;
  logic clk;
  logic n_rst;
  int   checks;
  int   errors;

  lsu_lq_if #(.ADDR_WIDTH(32), .TAG_WIDTH(6)) bus();

  lsu_lq #(.ADDR_WIDTH(32), .TAG_WIDTH(6), .LQ_DEPTH(8), .LQ_TAG_WIDTH(3)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clr();
    bus.i_flush           = 1'b0;
    bus.i_alloc_en        = 1'b0;
    bus.i_alloc_tag       = '0;
    bus.i_alloc_addr      = '0;
    bus.i_alloc_width     = '0;
    bus.i_sq_retire_en    = 1'b0;
    bus.i_sq_retire_addr  = '0;
    bus.i_sq_retire_width = '0;
    bus.i_lq_retire_en    = 1'b0;
    bus.i_lq_retire_tag   = '0;
  endtask

  task automatic set_alloc(input logic [5:0] tag, input logic [31:0] a, input logic [3:0] w);
    bus.i_alloc_en = 1'b1; bus.i_alloc_tag = tag; bus.i_alloc_addr = a; bus.i_alloc_width = w;
    $display("alloc  tag=%0d addr=%h width=%h", tag, a, w);
  endtask

  task automatic set_store(input logic [31:0] a, input logic [3:0] w);
    bus.i_sq_retire_en = 1'b1; bus.i_sq_retire_addr = a; bus.i_sq_retire_width = w;
    $display("store  addr=%h width=%h", a, w);
  endtask

  task automatic set_retire(input logic [5:0] tag);
    bus.i_lq_retire_en = 1'b1; bus.i_lq_retire_tag = tag;
    $display("retire tag=%0d", tag);
  endtask

  // Advance one edge and drop all requests (called at a negedge).
  task automatic step();
    @(negedge clk);
    clr();
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    clr();
    set_retire(6'd0);
    @(negedge clk); @(negedge clk);
    #1;
    checks++; if (bus.o_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", bus.o_full); end
    checks++; if (bus.o_lq_retire_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.o_lq_retire_valid); end
    checks++; if (bus.o_lq_retire_mis_speculated !== 1'b0) begin errors++; $display("FAIL reset_mis got %b want 0", bus.o_lq_retire_mis_speculated); end
    @(negedge clk);
    n_rst = 1'b1;
    clr();
  endtask

  task automatic test_fill_and_full();
    for (int i = 1; i <= 8; i++) begin
      set_alloc(6'(i), 32'h1000 + 32'(i * 16), 4'hF);
      step();
      checks++;
      if (bus.o_full !== (i == 8)) begin errors++; $display("FAIL fill_full_%0d got %b want %b", i, bus.o_full, (i == 8)); end
    end
    set_alloc(6'd9, 32'h2000, 4'hF);
    step();
    set_retire(6'd9);
    #1;
    checks++; if (bus.o_lq_retire_valid !== 1'b0) begin errors++; $display("FAIL dropped_tag9 got %b want 0", bus.o_lq_retire_valid); end
    checks++; if (bus.o_full !== 1'b1) begin errors++; $display("FAIL still_full got %b want 1", bus.o_full); end
    step();
  endtask

  task automatic test_full_retire_alloc();
    set_retire(6'd5);
    set_alloc(6'd20, 32'h3000, 4'hF);
    #1;
    checks++; if (bus.o_lq_retire_valid !== 1'b1) begin errors++; $display("FAIL full_ret5_valid got %b want 1", bus.o_lq_retire_valid); end
    checks++; if (bus.o_lq_retire_mis_speculated !== 1'b0) begin errors++; $display("FAIL full_ret5_mis got %b want 0", bus.o_lq_retire_mis_speculated); end
    step();
    checks++; if (bus.o_full !== 1'b0) begin errors++; $display("FAIL freed_slot_full got %b want 0", bus.o_full); end
    set_retire(6'd20);
    #1;
    checks++; if (bus.o_lq_retire_valid !== 1'b0) begin errors++; $display("FAIL tag20_dropped got %b want 0", bus.o_lq_retire_valid); end
    step();
    set_alloc(6'd20, 32'h3000, 4'hF);
    step();
    checks++; if (bus.o_full !== 1'b1) begin errors++; $display("FAIL refill_full got %b want 1", bus.o_full); end
    set_retire(6'd20);
    #1;
    checks++; if (bus.o_lq_retire_valid !== 1'b1) begin errors++; $display("FAIL tag20_landed got %b want 1", bus.o_lq_retire_valid); end
    step();
    bus.i_flush = 1'b1;
    $display("flush");
    step();
  endtask

  task automatic test_byte_overlap();
    set_alloc(6'd3, 32'h100, 4'h3); step();
    set_alloc(6'd4, 32'h100, 4'h3); step();
    set_store(32'h100, 4'hC); step();
    set_retire(6'd4);
    #1;
    checks++; if (bus.o_lq_retire_valid !== 1'b1) begin errors++; $display("FAIL nolap_valid got %b want 1", bus.o_lq_retire_valid); end
    checks++; if (bus.o_lq_retire_mis_speculated !== 1'b0) begin errors++; $display("FAIL nolap_mis got %b want 0", bus.o_lq_retire_mis_speculated); end
    step();
    set_store(32'h100, 4'h2); step();
    set_retire(6'd3);
    #1;
    checks++; if (bus.o_lq_retire_valid !== 1'b1) begin errors++; $display("FAIL lap_valid got %b want 1", bus.o_lq_retire_valid); end
    checks++; if (bus.o_lq_retire_mis_speculated !== 1'b1) begin errors++; $display("FAIL lap_mis got %b want 1", bus.o_lq_retire_mis_speculated); end
    step();
    set_retire(6'd3);
    #1;
    checks++; if (bus.o_lq_retire_valid !== 1'b0) begin errors++; $display("FAIL tag3_freed got %b want 0", bus.o_lq_retire_valid); end
    step();
  endtask

  task automatic test_diff_word();
    set_alloc(6'd7, 32'h104, 4'hF); step();
    set_store(32'h100, 4'hF); step();
    set_retire(6'd7);
    #1;
    checks++; if (bus.o_lq_retire_valid !== 1'b1) begin errors++; $display("FAIL diffword_valid got %b want 1", bus.o_lq_retire_valid); end
    checks++; if (bus.o_lq_retire_mis_speculated !== 1'b0) begin errors++; $display("FAIL diffword_mis got %b want 0", bus.o_lq_retire_mis_speculated); end
    step();
  endtask

  task automatic test_same_cycle_snoop();
    set_alloc(6'd10, 32'h200, 4'h1); step();
    set_store(32'h200, 4'h1);
    set_retire(6'd10);
    set_alloc(6'd11, 32'h200, 4'h1);
    #1;
    checks++; if (bus.o_lq_retire_valid !== 1'b1) begin errors++; $display("FAIL samecyc_valid got %b want 1", bus.o_lq_retire_valid); end
    checks++; if (bus.o_lq_retire_mis_speculated !== 1'b1) begin errors++; $display("FAIL samecyc_mis got %b want 1", bus.o_lq_retire_mis_speculated); end
    step();
    set_alloc(6'd12, 32'h200, 4'h2); step();
    set_retire(6'd11);
    #1;
    checks++; if (bus.o_lq_retire_mis_speculated !== 1'b1) begin errors++; $display("FAIL alloc_snoop_mis got %b want 1", bus.o_lq_retire_mis_speculated); end
    step();
    set_retire(6'd12);
    #1;
    checks++; if (bus.o_lq_retire_mis_speculated !== 1'b0) begin errors++; $display("FAIL later_load_mis got %b want 0", bus.o_lq_retire_mis_speculated); end
    step();
    set_retire(6'd10);
    #1;
    checks++; if (bus.o_lq_retire_valid !== 1'b0) begin errors++; $display("FAIL tag10_freed got %b want 0", bus.o_lq_retire_valid); end
    step();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) begin
      set_alloc(6'(30 + i), 32'h300 + 32'(i * 4), 4'h1);
      step();
    end
    set_store(32'h304, 4'h1); step();
    bus.i_flush = 1'b1;
    $display("flush");
    set_alloc(6'd40, 32'h400, 4'hF);
    set_retire(6'd30);
    step();
    checks++; if (bus.o_full !== 1'b0) begin errors++; $display("FAIL flush_full got %b want 0", bus.o_full); end
    for (int i = 0; i < 4; i++) begin
      set_retire(6'(30 + i));
      #1;
      checks++; if (bus.o_lq_retire_valid !== 1'b0) begin errors++; $display("FAIL flush_old_tag%0d got %b want 0", 30 + i, bus.o_lq_retire_valid); end
      step();
    end
    set_retire(6'd40);
    #1;
    checks++; if (bus.o_lq_retire_valid !== 1'b0) begin errors++; $display("FAIL flush_alloc40 got %b want 0", bus.o_lq_retire_valid); end
    step();
    set_alloc(6'd41, 32'h500, 4'h1); step();
    set_retire(6'd41);
    #1;
    checks++; if (bus.o_lq_retire_valid !== 1'b1) begin errors++; $display("FAIL post_flush_valid got %b want 1", bus.o_lq_retire_valid); end
    checks++; if (bus.o_lq_retire_mis_speculated !== 1'b0) begin errors++; $display("FAIL post_flush_mis got %b want 0", bus.o_lq_retire_mis_speculated); end
    step();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 8; i++) begin
      set_alloc(6'(50 + i), 32'h600, 4'h1);
      step();
    end
    set_store(32'h600, 4'h1);
    set_retire(6'd50);
    #1;
    checks++; if (bus.o_lq_retire_mis_speculated !== 1'b1) begin errors++; $display("FAIL prereset_mis got %b want 1", bus.o_lq_retire_mis_speculated); end
    checks++; if (bus.o_full !== 1'b1) begin errors++; $display("FAIL prereset_full got %b want 1", bus.o_full); end
    #1;
    n_rst = 1'b0;
    $display("async reset");
    #1;
    checks++; if (bus.o_full !== 1'b0) begin errors++; $display("FAIL areset_full got %b want 0", bus.o_full); end
    checks++; if (bus.o_lq_retire_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b want 0", bus.o_lq_retire_valid); end
    checks++; if (bus.o_lq_retire_mis_speculated !== 1'b0) begin errors++; $display("FAIL areset_mis got %b want 0", bus.o_lq_retire_mis_speculated); end
    @(negedge clk);
    n_rst = 1'b1;
    clr();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fill_and_full();
    test_full_retire_alloc();
    test_byte_overlap();
    test_diff_word();
    test_same_cycle_snoop();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
